tx_serializer: RTL

//   Parallel-to-serial TX stage in the Bit_Rate_Clk (5G) domain, downstream of the clock

---
 rtl/tx_serializer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/tx_serializer.sv
// Parallel-to-serial TX stage: loads 1/2/4 ten-bit symbols per frame and shifts them
// out LSB-first, one bit per Bit_Rate_Clk, filling with idle symbols when no frame is offered.
module tx_serializer #(
    parameter logic [9:0] IDLE_SYMBOL = 10'h17C
) (
    input  logic        Bit_Rate_Clk,
    input  logic        Rst,
    input  logic [5:0]  DataBusWidth,
    input  logic [39:0] TxSymbols,
    input  logic        TxValid,
    output logic        TxReady,
    output logic        TxSerial,
    output logic        Symbol_Start,
    output logic        Underrun
);

    typedef enum logic [0:0] {
        S_LOAD  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [5:0]  cnt_r;
    logic [5:0]  cnt_nxt_s;
    logic [5:0]  frame_len_r;
    logic [5:0]  frame_len_nxt_s;
    logic [39:0] shreg_r;
    logic [39:0] shreg_nxt_s;
    logic        tx_serial_r;
    logic        tx_serial_nxt_s;
    logic        symbol_start_r;
    logic        symbol_start_nxt_s;
    logic        underrun_r;
    logic        underrun_nxt_s;
    logic        ready_s;

    function automatic logic [5:0] decode_len(input logic [5:0] width);
        logic [5:0] len;
        case (width)
            6'd8:    len = 6'd10;
            6'd16:   len = 6'd20;
            6'd32:   len = 6'd40;
            default: len = 6'd10;
        endcase
        return len;
    endfunction

    // Ready on every edge that loads a frame: idle state, or the last bit of the current frame
    always_comb begin
        ready_s = 1'b0;
        if (state_r == S_LOAD) begin
            ready_s = 1'b1;
        end else begin
            ready_s = (cnt_r == (frame_len_r - 6'd1));
        end
    end

    // Next-state and datapath update; a load edge also emits the last bit of the old frame
    always_comb begin
        state_nxt_s        = state_r;
        cnt_nxt_s          = cnt_r;
        frame_len_nxt_s    = frame_len_r;
        shreg_nxt_s        = shreg_r;
        tx_serial_nxt_s    = tx_serial_r;
        symbol_start_nxt_s = symbol_start_r;
        underrun_nxt_s     = underrun_r;

        case (state_r)
            S_LOAD: begin
                tx_serial_nxt_s    = 1'b0;
                symbol_start_nxt_s = 1'b0;
            end
            S_SHIFT: begin
                tx_serial_nxt_s    = shreg_r[0];
                symbol_start_nxt_s = (cnt_r == 6'd0) | (cnt_r == 6'd10) |
                                     (cnt_r == 6'd20) | (cnt_r == 6'd30);
            end
            default: begin
                state_nxt_s        = S_LOAD;
                tx_serial_nxt_s    = 1'b0;
                symbol_start_nxt_s = 1'b0;
            end
        endcase

        if (ready_s) begin
            frame_len_nxt_s = decode_len(DataBusWidth);
            shreg_nxt_s     = TxValid ? TxSymbols : {4{IDLE_SYMBOL}};
            underrun_nxt_s  = underrun_r | ~TxValid;
            cnt_nxt_s       = 6'd0;
            state_nxt_s     = S_SHIFT;
        end else if (state_r == S_SHIFT) begin
            shreg_nxt_s = {1'b0, shreg_r[39:1]};
            cnt_nxt_s   = cnt_r + 6'd1;
        end else begin
            shreg_nxt_s = shreg_r;
            cnt_nxt_s   = cnt_r;
        end
    end

    // FSM state register
    always_ff @(posedge Bit_Rate_Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= S_LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers; reset discards any partial frame
    always_ff @(posedge Bit_Rate_Clk or posedge Rst) begin
        if (Rst) begin
            cnt_r          <= 6'd0;
            frame_len_r    <= 6'd10;
            shreg_r        <= 40'd0;
            tx_serial_r    <= 1'b0;
            symbol_start_r <= 1'b0;
            underrun_r     <= 1'b0;
        end else begin
            cnt_r          <= cnt_nxt_s;
            frame_len_r    <= frame_len_nxt_s;
            shreg_r        <= shreg_nxt_s;
            tx_serial_r    <= tx_serial_nxt_s;
            symbol_start_r <= symbol_start_nxt_s;
            underrun_r     <= underrun_nxt_s;
        end
    end

    assign TxReady      = ready_s;
    assign TxSerial     = tx_serial_r;
    assign Symbol_Start = symbol_start_r;
    assign Underrun     = underrun_r;

endmodule
